cw305_mem_loader: RTL
=====================

CW305_MEM_LOADER -- requirements
Module: cw305_mem_loader

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  pBYTECNT_SIZE, 7, register byte-count width.
  pADDR_WIDTH, 21, USB address width.
  pTIMEOUT, 255, cycles to wait for mem_gnt or mem_rvalid before abort (8-bit counter).
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  usb_clk  in  1  the only clock; all logic on its rising edge.
  resetn  in  1  synchronous, active-low reset.
  reg_address  in  pADDR_WIDTH-pBYTECNT_SIZE  register select from the USB front end.
  reg_bytecnt  in  pBYTECNT_SIZE  byte index within the register.
  write_data  in  8  host write byte.
  read_data  out  8  host read byte.
  reg_write  in  1  one-cycle host write strobe.
  reg_read  in  1  host read in progress.
  reg_addrvalid  in  1  reg_address is valid.
  mem_req  out  1  memory request, held until granted.
  mem_we  out  1  1 = write, 0 = read.
  mem_be  out  4  byte enables, constant 4'b1111.
  mem_addr  out  32  word address, bits [1:0] always 0.
  mem_wdata  out  32  write data.
  mem_gnt  in  1  request accepted.
  mem_rvalid  in  1  response valid; completes write or returns read data.
  mem_rdata  in  32  read data, valid with mem_rvalid.
  busy  out  1  transaction in flight.

Function
REQ-003 The register map SHALL be as follows; byte n = bits [8n+7:8n]; bytecnt > 3 reads 0x00 and writes are ignored.
  0x20 ADDR: R/W, 32 bits; bits [1:0] stored as 0.
  0x21 WDATA: R/W, 32 bits.
  0x22 CTRL: bit0 START_RD (write-1, self-clearing, reads 0); bit1 AUTOINC (R/W).
  0x23 STATUS: bit0 busy; bit1 OVERRUN (sticky); bit2 RD_VALID; bit3 TIMEOUT (sticky); writing 1 to bit1 or bit3 clears that bit.
  0x24 RDATA: read-only.
REQ-004 read_data SHALL be a combinational decode of reg_address/reg_bytecnt, gated by reg_addrvalid; unmapped address -> 0x00.
REQ-005 A write to WDATA bytecnt 3 in IDLE SHALL launch a write; CTRL.START_RD=1 in IDLE SHALL launch a read.
REQ-006 The FSM SHALL have states IDLE -> REQ -> WAIT_RV -> IDLE; busy=1 in REQ and WAIT_RV.
REQ-007 The cycle after launch SHALL enter REQ: mem_req=1, with mem_we/mem_addr/mem_wdata driven from the registers; these are held stable until mem_gnt.
REQ-008 In REQ, mem_gnt=1 SHALL deassert mem_req on the next edge and go to WAIT_RV; mem_rvalid is ignored in REQ.
REQ-009 In WAIT_RV, mem_rvalid=1 SHALL return to IDLE. For a read, RDATA<=mem_rdata and RD_VALID<=1. If AUTOINC=1, ADDR<=ADDR+4 modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
REQ-010 Any launch, or any ADDR/WDATA/CTRL write, while busy SHALL be ignored, leave all registers unchanged, and set OVERRUN.
REQ-011 A new launch SHALL clear RD_VALID.
REQ-012 The timeout counter SHALL clear on entry to REQ and to WAIT_RV and increment each cycle in those states. Reaching pTIMEOUT without the awaited event SHALL force IDLE, mem_req=0, set TIMEOUT, and leave ADDR unchanged.
REQ-013 A launch and a STATUS clear in the same cycle SHALL both take effect.

Reset
REQ-014 resetn=0 on a rising edge SHALL reset, mid-transaction included: FSM=IDLE, mem_req=0, mem_we=0, ADDR=WDATA=RDATA=0, CTRL=0, STATUS=0, timeout counter=0; mem_be stays 4'b1111.

Verification
REQ-015 ADDR=0x00000100, WDATA=0xDEADBEEF, memory gnt after 2 cycles, rvalid 1 cycle later -> one write: mem_addr=0x100, mem_wdata=0xDEADBEEF, mem_we=1; busy falls after rvalid.
REQ-016 AUTOINC=1, ADDR=0xFFFFFFFC, two word writes -> mem_addr=0xFFFFFFFC, then 0x00000000; final ADDR=0x00000004.
REQ-017 START_RD with mem_rdata=0x12345678 -> RDATA reads bytes 78,56,34,12; RD_VALID=1; mem_we=0.
REQ-018 WDATA byte-3 write while in WAIT_RV -> no second mem_req, WDATA unchanged, OVERRUN=1; write 0x02 to STATUS -> OVERRUN=0.
REQ-019 mem_gnt held 0 -> mem_req drops after exactly 255 cycles in REQ, TIMEOUT=1, busy=0.
REQ-020 resetn=0 while in REQ -> next edge mem_req=0, all registers 0.

Source files
------------

// File: rtl/cw305_mem_loader_if.sv
// Word-wide memory bus between the USB register loader and a memory/SoC port.
// The loader drives a request with address/data and waits for grant, then a response.
interface cw305_mem_loader_if;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/cw305_mem_loader.sv
// USB register front end that stages one 32-bit word transfer onto a
// request/grant/response memory bus, with overrun and timeout reporting.
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   S_IDLE    | no transfer; registers writable, launches accepted
//   S_REQ     | mem_req high, address/data/we held until mem_gnt
//   S_WAIT_RV | request granted, waiting for mem_rvalid
module cw305_mem_loader #(
    parameter int pBYTECNT_SIZE = 7,
    parameter int pADDR_WIDTH   = 21,
    parameter int pTIMEOUT      = 255
) (
    input  logic                                 usb_clk,
    input  logic                                 resetn,
    input  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address,
    input  logic [pBYTECNT_SIZE-1:0]             reg_bytecnt,
    input  logic [7:0]                           write_data,
    output logic [7:0]                           read_data,
    input  logic                                 reg_write,
    input  logic                                 reg_read,
    input  logic                                 reg_addrvalid,
    output logic                                 busy,
    cw305_mem_loader_if.master                   mem
);

    localparam int AW = pADDR_WIDTH - pBYTECNT_SIZE;

    localparam logic [AW-1:0] A_ADDR   = AW'(8'h20);
    localparam logic [AW-1:0] A_WDATA  = AW'(8'h21);
    localparam logic [AW-1:0] A_CTRL   = AW'(8'h22);
    localparam logic [AW-1:0] A_STATUS = AW'(8'h23);
    localparam logic [AW-1:0] A_RDATA  = AW'(8'h24);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQ     = 2'd1;
    localparam logic [1:0] S_WAIT_RV = 2'd2;

    // Last count value before abort; the counter starts at 0 on state entry.
    localparam logic [7:0] TO_LAST = 8'(pTIMEOUT - 1);

    logic [1:0]  state;
    logic [7:0]  to_cnt;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        autoinc_q;
    logic        overrun_q;
    logic        rd_valid_q;
    logic        timeout_q;

    // The host read strobe carries no information beyond reg_addrvalid here.
    logic unused_reg_read;
    assign unused_reg_read = reg_read;

    logic       wr_en, byte_ok, idle;
    logic [1:0] idx;
    logic       wr_addr, wr_wdata, wr_ctrl, wr_status;
    logic       launch_wr, launch_rd, launch;
    logic       overrun_set, rsp_done, timeout_hit;

    assign idle     = (state == S_IDLE);
    assign busy     = ~idle;
    assign wr_en    = reg_write & reg_addrvalid;
    assign byte_ok  = (reg_bytecnt < pBYTECNT_SIZE'(4));
    assign idx      = reg_bytecnt[1:0];

    assign wr_addr   = wr_en & (reg_address == A_ADDR);
    assign wr_wdata  = wr_en & (reg_address == A_WDATA);
    assign wr_ctrl   = wr_en & (reg_address == A_CTRL);
    assign wr_status = wr_en & (reg_address == A_STATUS) & byte_ok & (idx == 2'd0);

    assign launch_wr = idle & wr_wdata & byte_ok & (idx == 2'd3);
    assign launch_rd = idle & wr_ctrl & byte_ok & (idx == 2'd0) & write_data[0];
    assign launch    = launch_wr | launch_rd;

    // Any attempt to touch the transfer registers mid-flight is dropped and flagged.
    assign overrun_set = busy & (wr_addr | wr_wdata | wr_ctrl);
    assign rsp_done    = (state == S_WAIT_RV) & mem.mem_rvalid;
    assign timeout_hit = (to_cnt == TO_LAST) &
                         (((state == S_REQ) & ~mem.mem_gnt) |
                          ((state == S_WAIT_RV) & ~mem.mem_rvalid));

    assign mem.mem_req   = (state == S_REQ);
    assign mem.mem_we    = we_q;
    assign mem.mem_be    = 4'b1111;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

    function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] i,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = w;
        case (i)
            2'd0: r[7:0]   = b;
            2'd1: r[15:8]  = b;
            2'd2: r[23:16] = b;
            default: r[31:24] = b;
        endcase
        return r;
    endfunction

    // Transfer sequencing: launch, wait for grant, wait for response, timeout abort.
    always_ff @(posedge usb_clk) begin
        if (!resetn) begin
            state  <= S_IDLE;
            to_cnt <= 8'd0;
            we_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (launch) begin
                        state  <= S_REQ;
                        to_cnt <= 8'd0;
                        we_q   <= launch_wr;
                    end
                end
                S_REQ: begin
                    if (mem.mem_gnt) begin
                        state  <= S_WAIT_RV;
                        to_cnt <= 8'd0;
                    end else if (timeout_hit) begin
                        state <= S_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
                end
                S_WAIT_RV: begin
                    if (mem.mem_rvalid || timeout_hit) begin
                        state <= S_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Host-writable transfer registers; frozen while a transfer is in flight.
    always_ff @(posedge usb_clk) begin
        if (!resetn) begin
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            autoinc_q <= 1'b0;
        end else if (idle) begin
            if (wr_addr && byte_ok)
                addr_q <= put_byte(addr_q, idx, write_data) & 32'hFFFF_FFFC;
            if (wr_wdata && byte_ok)
                wdata_q <= put_byte(wdata_q, idx, write_data);
            if (wr_ctrl && byte_ok && idx == 2'd0)
                autoinc_q <= write_data[1];
        end else if (rsp_done && autoinc_q) begin
            addr_q <= addr_q + 32'd4;
        end
    end

    // Read capture and sticky status flags.
    always_ff @(posedge usb_clk) begin
        if (!resetn) begin
            rdata_q    <= 32'h0;
            rd_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            if (launch)
                rd_valid_q <= 1'b0;
            else if (rsp_done && !we_q) begin
                rdata_q    <= mem.mem_rdata;
                rd_valid_q <= 1'b1;
            end

            if (overrun_set)
                overrun_q <= 1'b1;
            else if (wr_status && write_data[1])
                overrun_q <= 1'b0;

            if (timeout_hit)
                timeout_q <= 1'b1;
            else if (wr_status && write_data[3])
                timeout_q <= 1'b0;
        end
    end

    // Combinational register read-back, byte-selected by reg_bytecnt.
    always_comb begin
        logic [31:0] word;
        word = 32'h0;
        case (reg_address)
            A_ADDR:   word = addr_q;
            A_WDATA:  word = wdata_q;
            A_CTRL:   word = {30'h0, autoinc_q, 1'b0};
            A_STATUS: word = {28'h0, timeout_q, rd_valid_q, overrun_q, busy};
            A_RDATA:  word = rdata_q;
            default:  word = 32'h0;
        endcase
        read_data = 8'h00;
        if (reg_addrvalid && byte_ok) begin
            case (idx)
                2'd0: read_data = word[7:0];
                2'd1: read_data = word[15:8];
                2'd2: read_data = word[23:16];
                default: read_data = word[31:24];
            endcase
        end
    end

endmodule
